// File: rtl/ring_meas_pkg.sv
// ---------------------------------------------------------------------------
// ring_meas_pkg
// Shared definitions for the ring-oscillator measurement sweep controller:
// the sweep FSM state encoding, width helpers and default timing constants.
// ---------------------------------------------------------------------------
package ring_meas_pkg;

    localparam int DEF_CHANNELS = 5;
    localparam int DEF_GATE     = 1000;
    localparam int DEF_SETTLE   = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_GATE    = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_NEXT    = 3'd5,
        ST_HOLD    = 3'd6
    } state_e;

    // Channel index width; a single channel still needs one index bit.
    function automatic int ch_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Down-counter width large enough to hold the longest state length.
    function automatic int cnt_w(input int gate, input int settle);
        return $clog2(((gate > settle) ? gate : settle) + 1);
    endfunction

endpackage

// File: rtl/ring_chan_next.sv
// ---------------------------------------------------------------------------
// ring_chan_next
// Combinational channel finder.
//   mask_i   : channel enable mask
//   idx_i    : current channel index
//   next_o   : next enabled index strictly above idx_i (0 when none)
//   last_o   : 1 when no enabled index lies above idx_i
//   lowest_o : lowest enabled index in mask_i (0 when mask is empty)
// ---------------------------------------------------------------------------
module ring_chan_next #(
    parameter int N = 5,
    parameter int W = 3
) (
    input  logic [N-1:0] mask_i,
    input  logic [W-1:0] idx_i,
    output logic [W-1:0] next_o,
    output logic         last_o,
    output logic [W-1:0] lowest_o
);

    // Scan from the top so the final hit is the lowest qualifying index.
    always_comb begin
        next_o   = '0;
        last_o   = 1'b1;
        lowest_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (mask_i[i]) begin
                lowest_o = W'(i);
                if (W'(i) > idx_i) begin
                    next_o = W'(i);
                    last_o = 1'b0;
                end else begin
                end
            end else begin
            end
        end
    end

endmodule

// File: rtl/ring_meas_sched.sv
// ---------------------------------------------------------------------------
// ring_meas_sched
// Sweep controller for the ring-oscillator measurement array. Serves each
// enabled channel in turn: clear hold, gate window of pGATE clocks, settle,
// then a one-cycle capture strobe.
//   i_clk, i_rst_n : reference clock, async active-low reset
//   i_start        : start a sweep (sampled in IDLE only)
//   i_auto         : restart automatically after the last channel
//   i_hold         : pause between channels
//   i_mask         : channel enables, latched at sweep start
//   o_clr, o_gate  : one-hot counter clear / count enable
//   o_cap, o_chan  : capture strobe and current channel index
//   o_busy, o_done : not-idle flag and end-of-sweep pulse
// All outputs are registered.
// ---------------------------------------------------------------------------
module ring_meas_sched
    import ring_meas_pkg::*;
#(
    parameter int pCHANNELS = DEF_CHANNELS,
    parameter int pGATE     = DEF_GATE,
    parameter int pSETTLE   = DEF_SETTLE
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_start,
    input  logic                         i_auto,
    input  logic                         i_hold,
    input  logic [pCHANNELS-1:0]         i_mask,
    output logic [pCHANNELS-1:0]         o_clr,
    output logic [pCHANNELS-1:0]         o_gate,
    output logic                         o_cap,
    output logic [$clog2(pCHANNELS)-1:0] o_chan,
    output logic                         o_busy,
    output logic                         o_done
);

    localparam int CH_W  = ch_w(pCHANNELS);
    localparam int CNT_W = cnt_w(pGATE, pSETTLE);

    localparam logic [CNT_W-1:0]     CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]     GATE_LD   = CNT_W'(pGATE);
    localparam logic [CNT_W-1:0]     SETTLE_LD = CNT_W'(pSETTLE);
    localparam logic [pCHANNELS-1:0] OH_BASE   = pCHANNELS'(1);

    state_e                 state_q, state_d;
    logic [pCHANNELS-1:0]   mask_q, mask_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   last_q, last_d;
    logic [CH_W-1:0]        chan_d;
    logic                   done_d;

    logic [pCHANNELS-1:0]   find_mask_s;
    logic [CH_W-1:0]        next_idx_s;
    logic [CH_W-1:0]        low_idx_s;
    logic                   last_s;
    logic [pCHANNELS-1:0]   onehot_s;

    // Finder input: the live mask whenever a fresh mask is about to be latched
    // (IDLE, or NEXT after the final channel), otherwise the latched mask.
    always_comb begin
        if ((state_q == ST_IDLE) || ((state_q == ST_NEXT) && last_q)) begin
            find_mask_s = i_mask;
        end else begin
            find_mask_s = mask_q;
        end
    end

    ring_chan_next #(
        .N (pCHANNELS),
        .W (CH_W)
    ) u_find (
        .mask_i   (find_mask_s),
        .idx_i    (o_chan),
        .next_o   (next_idx_s),
        .last_o   (last_s),
        .lowest_o (low_idx_s)
    );

    // Next-state logic; the down-counter is loaded on entry to every timed
    // state and the state exits when the counter reads 1.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        chan_d  = o_chan;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start && (i_mask != '0)) begin
                    mask_d  = i_mask;
                    chan_d  = low_idx_s;
                    cnt_d   = SETTLE_LD;
                    state_d = ST_CLEAR;
                end else begin
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                if (cnt_q == CNT_ONE) begin
                    cnt_d   = GATE_LD;
                    state_d = ST_GATE;
                end else begin
                    cnt_d   = cnt_q - CNT_ONE;
                end
            end
            ST_GATE: begin
                if (cnt_q == CNT_ONE) begin
                    cnt_d   = SETTLE_LD;
                    state_d = ST_SETTLE;
                end else begin
                    cnt_d   = cnt_q - CNT_ONE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == CNT_ONE) begin
                    cnt_d   = CNT_ONE;
                    state_d = ST_CAPTURE;
                end else begin
                    cnt_d   = cnt_q - CNT_ONE;
                end
            end
            ST_CAPTURE: begin
                // Decide "last channel" here so NEXT can steer the finder
                // to the live mask for the wrap-around.
                last_d  = last_s;
                done_d  = last_s;
                cnt_d   = CNT_ONE;
                state_d = ST_NEXT;
            end
            ST_NEXT: begin
                cnt_d = SETTLE_LD;
                if (!last_q) begin
                    chan_d  = next_idx_s;
                    state_d = i_hold ? ST_HOLD : ST_CLEAR;
                end else if (i_auto) begin
                    mask_d = i_mask;
                    if (i_mask != '0) begin
                        chan_d  = low_idx_s;
                        state_d = i_hold ? ST_HOLD : ST_CLEAR;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (!i_hold) begin
                    cnt_d   = SETTLE_LD;
                    state_d = ST_CLEAR;
                end else begin
                    cnt_d   = SETTLE_LD;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign onehot_s = OH_BASE << chan_d;

    // State, counter and registered outputs; outputs are decoded from the
    // next state so they line up with the state they belong to.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            mask_q  <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            o_chan  <= '0;
            o_clr   <= '0;
            o_gate  <= '0;
            o_cap   <= 1'b0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            o_chan  <= chan_d;
            o_clr   <= (state_d == ST_CLEAR) ? onehot_s : '0;
            o_gate  <= (state_d == ST_GATE)  ? onehot_s : '0;
            o_cap   <= (state_d == ST_CAPTURE);
            o_busy  <= (state_d != ST_IDLE);
            o_done  <= done_d;
        end
    end

endmodule

// File: tb/tb_ring_meas_sched.sv
// ---------------------------------------------------------------------------
// tb_ring_meas_sched
// Self-checking bench for ring_meas_sched (5 channels, gate 10, settle 2).
// Stimulus is held in per-cycle arrays; a timeline model builds the expected
// per-cycle outputs from the sweep rules (segment lengths, channel order,
// hold/auto decisions) and the DUT is compared every cycle.
// ---------------------------------------------------------------------------
module tb_ring_meas_sched;

    localparam int NCH  = 5;
    localparam int G    = 10;
    localparam int S    = 2;
    localparam int MAXC = 1024;

    logic       clk;
    logic       i_rst_n;
    logic       i_start;
    logic       i_auto;
    logic       i_hold;
    logic [4:0] i_mask;
    logic [4:0] o_clr;
    logic [4:0] o_gate;
    logic       o_cap;
    logic [2:0] o_chan;
    logic       o_busy;
    logic       o_done;

    int tests;
    int fails;

    bit         s_start [MAXC];
    bit         s_auto  [MAXC];
    bit         s_hold  [MAXC];
    logic [4:0] s_mask  [MAXC];

    logic [4:0] e_clr  [MAXC];
    logic [4:0] e_gate [MAXC];
    bit         e_cap  [MAXC];
    bit         e_busy [MAXC];
    bit         e_done [MAXC];
    logic [2:0] e_chan [MAXC];

    ring_meas_sched #(
        .pCHANNELS (NCH),
        .pGATE     (G),
        .pSETTLE   (S)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (i_rst_n),
        .i_start (i_start),
        .i_auto  (i_auto),
        .i_hold  (i_hold),
        .i_mask  (i_mask),
        .o_clr   (o_clr),
        .o_gate  (o_gate),
        .o_cap   (o_cap),
        .o_chan  (o_chan),
        .o_busy  (o_busy),
        .o_done  (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int low_of(input logic [4:0] m);
        for (int i = 0; i < NCH; i++) begin
            if (m[i]) return i;
        end
        return 0;
    endfunction

    function automatic int next_of(input logic [4:0] m, input int ch);
        for (int i = ch + 1; i < NCH; i++) begin
            if (m[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [4:0] oh(input int ch);
        logic [4:0] one;
        one = 5'b00001;
        return one << ch;
    endfunction

    function automatic void put(input int c, input logic [4:0] clr, input logic [4:0] gate,
                                input bit cap, input bit busy, input bit done, input int ch);
        if (c >= 0 && c < MAXC) begin
            e_clr[c]  = clr;
            e_gate[c] = gate;
            e_cap[c]  = cap;
            e_busy[c] = busy;
            e_done[c] = done;
            e_chan[c] = 3'(ch);
        end
    endfunction

    task automatic clear_stim();
        for (int c = 0; c < MAXC; c++) begin
            s_start[c] = 1'b0;
            s_auto[c]  = 1'b0;
            s_hold[c]  = 1'b0;
            s_mask[c]  = 5'b00000;
            put(c, 5'b00000, 5'b00000, 1'b0, 1'b0, 1'b0, 0);
        end
    endtask

    // Timeline model: each served channel is S clear + G gate + S settle +
    // 1 capture + 1 next cycle; decisions use the inputs seen on NEXT/HOLD.
    task automatic build_model(input int n);
        int c, d, nx, ch;
        bit act, hl;
        logic [4:0] m;
        ch = 0; m = 5'b00000; c = 0; act = 1'b0;
        while (c < n) begin
            if (!act) begin
                put(c, 5'b00000, 5'b00000, 1'b0, 1'b0, 1'b0, ch);
                if (s_start[c] && s_mask[c] != 5'b00000) begin
                    m = s_mask[c];
                    ch = low_of(m);
                    act = 1'b1;
                end
                c++;
            end else begin
                for (int k = 0; k < S; k++) put(c + k, oh(ch), 5'b00000, 1'b0, 1'b1, 1'b0, ch);
                for (int k = 0; k < G; k++) put(c + S + k, 5'b00000, oh(ch), 1'b0, 1'b1, 1'b0, ch);
                for (int k = 0; k < S; k++) put(c + S + G + k, 5'b00000, 5'b00000, 1'b0, 1'b1, 1'b0, ch);
                put(c + 2*S + G, 5'b00000, 5'b00000, 1'b1, 1'b1, 1'b0, ch);
                d  = c + 2*S + G + 1;
                nx = next_of(m, ch);
                put(d, 5'b00000, 5'b00000, 1'b0, 1'b1, (nx < 0), ch);
                c = d + 1;
                if (nx >= 0) begin
                    ch = nx;
                end else if (s_auto[d] && s_mask[d] != 5'b00000) begin
                    m = s_mask[d];
                    ch = low_of(m);
                end else begin
                    act = 1'b0;
                end
                if (act && s_hold[d]) begin
                    hl = 1'b1;
                    while (hl) begin
                        put(c, 5'b00000, 5'b00000, 1'b0, 1'b1, 1'b0, ch);
                        if (!s_hold[c] || c >= MAXC - 2) hl = 1'b0;
                        c++;
                    end
                end
            end
        end
    endtask

    task automatic do_reset();
        i_start = 1'b0; i_auto = 1'b0; i_hold = 1'b0; i_mask = 5'b00000;
        i_rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        i_rst_n = 1'b1;
    endtask

    // Starts at the negedge right after reset release; compares, then drives.
    task automatic run_check(input int n, input string name);
        logic [15:0] obs, exp;
        build_model(n);
        for (int c = 0; c < n; c++) begin
            if (c > 0) @(negedge clk);
            obs = {o_clr, o_gate, o_cap, o_chan, o_busy, o_done};
            exp = {e_clr[c], e_gate[c], e_cap[c], e_chan[c], e_busy[c], e_done[c]};
            tests++;
            if (obs !== exp) begin
                fails++;
                $display("FAIL %s cyc %0d: got clr=%b gate=%b cap=%b chan=%0d busy=%b done=%b, want clr=%b gate=%b cap=%b chan=%0d busy=%b done=%b",
                         name, c, o_clr, o_gate, o_cap, o_chan, o_busy, o_done,
                         e_clr[c], e_gate[c], e_cap[c], e_chan[c], e_busy[c], e_done[c]);
            end
            i_start = s_start[c];
            i_auto  = s_auto[c];
            i_hold  = s_hold[c];
            i_mask  = s_mask[c];
        end
    endtask

    task automatic test_reset();
        clear_stim();
        do_reset();
        tests++;
        if ({o_clr, o_gate, o_cap, o_chan, o_busy, o_done} !== 16'h0000) begin
            fails++;
            $display("FAIL reset_state: got %h, want 0000", {o_clr, o_gate, o_cap, o_chan, o_busy, o_done});
        end
        run_check(8, "reset_idle");
    endtask

    task automatic test_basic_sweep();
        clear_stim();
        s_start[0] = 1'b1;
        for (int c = 0; c < MAXC; c++) s_mask[c] = 5'b10101;
        do_reset();
        run_check(60, "basic_sweep");
    endtask

    task automatic test_zero_mask();
        clear_stim();
        for (int c = 0; c < 30; c++) s_start[c] = 1'b1;
        do_reset();
        run_check(30, "zero_mask");
    endtask

    task automatic test_auto_remask();
        clear_stim();
        s_start[0] = 1'b1;
        for (int c = 0; c < MAXC; c++) begin
            s_mask[c] = (c < 10) ? 5'b00011 : 5'b10000;
            s_auto[c] = (c < 40);
        end
        do_reset();
        run_check(75, "auto_remask");
    endtask

    task automatic test_hold();
        clear_stim();
        s_start[0] = 1'b1;
        for (int c = 0; c < MAXC; c++) s_mask[c] = 5'b00011;
        for (int c = 5; c < 23; c++) s_hold[c] = 1'b1;
        do_reset();
        run_check(60, "hold");
    endtask

    task automatic test_async_reset();
        logic [15:0] obs;
        clear_stim();
        s_start[0] = 1'b1;
        for (int c = 0; c < MAXC; c++) s_mask[c] = 5'b10101;
        do_reset();
        run_check(24, "pre_reset");
        #2;
        i_rst_n = 1'b0;
        #1;
        obs = {o_clr, o_gate, o_cap, o_chan, o_busy, o_done};
        tests++;
        if (obs !== 16'h0000) begin
            fails++;
            $display("FAIL async_reset_drop: got %h, want 0000", obs);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            tests++;
            if ({o_cap, o_done, o_busy} !== 3'b000) begin
                fails++;
                $display("FAIL reset_held cyc %0d: got cap/done/busy=%b, want 000", k, {o_cap, o_done, o_busy});
            end
        end
        clear_stim();
        s_start[0] = 1'b1;
        for (int c = 0; c < MAXC; c++) s_mask[c] = 5'b10110;
        i_rst_n = 1'b1;
        run_check(60, "post_reset");
    endtask

    task automatic test_random();
        logic [4:0] cur_mask;
        bit hst, ast;
        for (int it = 0; it < 4; it++) begin
            clear_stim();
            cur_mask = 5'($urandom_range(1, 31));
            hst = 1'b0;
            ast = 1'($urandom_range(0, 1));
            for (int c = 0; c < 400; c++) begin
                if ($urandom_range(0, 11) == 0) cur_mask = 5'($urandom_range(0, 31));
                if ($urandom_range(0, 19) == 0) hst = ~hst;
                if ($urandom_range(0, 59) == 0) ast = ~ast;
                s_mask[c]  = cur_mask;
                s_hold[c]  = hst;
                s_auto[c]  = ast;
                s_start[c] = ($urandom_range(0, 7) == 0);
            end
            do_reset();
            run_check(300, "random");
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        i_rst_n = 1'b0; i_start = 1'b0; i_auto = 1'b0; i_hold = 1'b0; i_mask = 5'b00000;
        test_reset();
        test_basic_sweep();
        test_zero_mask();
        test_auto_remask();
        test_hold();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ring_meas_sched.md
# ring_meas_sched

Sweep controller for the ring-oscillator measurement array. It steps through the enabled ring channels one at a time. For each channel it clears the counter, opens a counting gate of exactly `pGATE` reference clocks, waits for the frozen count to settle across domains, then strobes capture. It sits between the reference-clock domain (`i_clk`) and the per-ring grey counters and capture registers, replacing free-running counting with gated, repeatable measurements.

## Interface
Parameters:
- `pCHANNELS`, 5, number of ring channels (2..8)
- `pGATE`, 1000, gate window length in `i_clk` cycles (≥1)
- `pSETTLE`, 4, clear-hold and post-gate settle length in `i_clk` cycles (≥2; covers ring-domain synchronizers)

Ports:
- `i_clk`, in, 1, reference clock
- `i_rst_n`, in, 1, reset; one clock; reset is asynchronous and active-low
- `i_start`, in, 1, level; begins a sweep when sampled high in IDLE
- `i_auto`, in, 1, restart a new sweep automatically after the last channel
- `i_hold`, in, 1, pause between channels
- `i_mask`, in, `pCHANNELS`, channel enables; latched at sweep start
- `o_clr`, out, `pCHANNELS`, one-hot counter clear
- `o_gate`, out, `pCHANNELS`, one-hot count enable
- `o_cap`, out, 1, one-cycle capture strobe for channel `o_chan`
- `o_chan`, out, `$clog2(pCHANNELS)`, current channel index
- `o_busy`, out, 1, high whenever state ≠ IDLE
- `o_done`, out, 1, one-cycle pulse at end of each sweep

## Operation
- All outputs are registered. Reset value: every output 0, state IDLE, `o_chan` 0, mask register 0.
- FSM states: IDLE, CLEAR, GATE, SETTLE, CAPTURE, NEXT, HOLD.
- **IDLE:** if `i_start`=1 and `i_mask`≠0, latch the mask, set `o_chan` to the lowest set bit, and go to CLEAR. Otherwise stay in IDLE. An all-zero mask is ignored.
- **CLEAR:** `o_clr[o_chan]`=1 for `pSETTLE` cycles, then go to GATE.
- **GATE:** `o_gate[o_chan]`=1 for exactly `pGATE` cycles, then go to SETTLE.
- **SETTLE:** all strobes low for `pSETTLE` cycles, then go to CAPTURE.
- **CAPTURE:** `o_cap`=1 for 1 cycle, then go to NEXT.
- **NEXT (1 cycle):**
  - If a higher enabled channel exists: advance `o_chan` to it. Go to HOLD if `i_hold`=1, else CLEAR.
  - If this was the last enabled channel: pulse `o_done`. If `i_auto`=1, re-latch `i_mask`. If the new mask ≠0, go to the lowest set channel (via HOLD if `i_hold`). Otherwise go to IDLE.
- **HOLD:** stay while `i_hold`=1; `o_chan` holds its value. Go to CLEAR the cycle after `i_hold` is sampled low.
- Only one bit of `o_clr`/`o_gate` is ever high, and never both in the same cycle.
- `i_start` outside IDLE is ignored. Changes to `i_mask` mid-sweep are ignored until the next latch.
- Async reset mid-operation: all strobes drop immediately, state goes to IDLE, and no `o_cap`/`o_done` is emitted.

## Timing
- Latency from `i_start` sampled high to first `o_clr` high: 1 cycle.
- Per-channel period with no hold: `pSETTLE` + `pGATE` + `pSETTLE` + 1 + 1 cycles.
- `o_cap` asserts exactly `pGATE` + `pSETTLE` cycles after the first `o_gate` cycle of that channel.
- `o_done` and the last channel's NEXT occupy the same cycle. With `i_auto`, the next sweep's `o_clr` rises the following cycle.
- A single down-counter of width `$clog2(max(pGATE, pSETTLE)+1)` is loaded on each state entry and expires at 1. It never wraps or underflows.
- Channel index wrap: after the highest enabled index, return to the lowest set bit of the freshly latched mask.

## Structure
- Package `ring_meas_pkg`: FSM state enum, `CH_W` = `$clog2(pCHANNELS)` helper, and the default timing constants.
- Sub-module `ring_chan_next`: combinational finder. Given the mask and the current index, it returns the next higher set index, a `last` flag, and the lowest set index. It is instantiated once.

## Test plan
Bench uses `pCHANNELS`=5, `pGATE`=10, `pSETTLE`=2, giving a 16-cycle channel period.
- Mask 5'b10101, `i_start` pulse, `i_auto`=0: channels 0, 2, 4 are served in order. Each gets 2 `o_clr`, 10 `o_gate`, then `o_cap` 12 cycles after gate start. `o_done` pulses once at cycle 48, then IDLE.
- Mask 0 with `i_start`=1: stays IDLE, `o_busy`=0, no strobes.
- Mask 5'b00011, `i_auto`=1, `i_mask` changed to 5'b10000 mid-sweep: channels 0 and 1 complete, `o_done` pulses, next sweep serves channel 4 only.
- `i_hold` raised during channel 0 GATE and released 7 cycles after NEXT: `o_chan`=1 and no strobes during the hold, `o_clr[1]` rises 1 cycle after release is sampled.
- `i_rst_n` asserted mid-GATE on channel 2: `o_gate` falls asynchronously, all outputs read 0, no `o_cap`. After release, a new `i_start` begins again from the lowest enabled channel.
